// File: rtl/cond_unit.sv
// ARM-style condition unit with per-context NZCV flags and IT-block sequencing.
// Outputs are combinational on the stored state of the selected context.
module cond_unit #(
  parameter int NCTX = 1,
  parameter int CW   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Valid,
  input  logic [CW-1:0] Ctx,
  input  logic [3:0]    Cond,
  input  logic [3:0]    ALUFlags,
  input  logic [1:0]    FlagW,
  input  logic          PCS,
  input  logic          RegW,
  input  logic          MemW,
  input  logic          Branch,
  input  logic          ITStart,
  input  logic [3:0]    ITCond,
  input  logic [1:0]    ITLen,
  input  logic [3:0]    ITMask,
  output logic          PCSrc,
  output logic          RegWrite,
  output logic          MemWrite,
  output logic          CondEx,
  output logic          Undef,
  output logic          ITActive,
  output logic [3:0]    Flags
);

  typedef struct packed {
    logic [1:0] nz;
    logic [1:0] cv;
    logic [2:0] cnt;
    logic [3:0] cnd;
    logic [3:0] msk;
  } ctx_t;

  ctx_t ctx_q [NCTX];
  ctx_t ctx_d [NCTX];

  ctx_t       cur;
  logic       vld;
  logic       in_it;
  logic [3:0] eff_cond;
  logic       cond_true;
  logic       it_start;
  logic       it_nest;
  logic       exec_op;
  logic       it_step;
  logic       n_f, z_f, c_f, v_f;

  // Out-of-range Ctx selects nothing, which forces Valid low for that cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // hold its previous value and infer a latch.
    cur = '0;
    vld = 1'b0;
    for (int i = 0; i < NCTX; i++) begin
      if (Ctx == CW'(i)) begin
        cur = ctx_q[i];
        vld = Valid;
      end
    end
  end

  assign in_it    = (cur.cnt != 3'd0);
  assign eff_cond = in_it ? {cur.cnd[3:1], cur.cnd[0] ^ ~cur.msk[0]} : Cond;
  assign {n_f, z_f} = cur.nz;
  assign {c_f, v_f} = cur.cv;

  always_comb begin
    cond_true = 1'b0;
    unique case (eff_cond)
      4'b0000: cond_true = z_f;
      4'b0001: cond_true = ~z_f;
      4'b0010: cond_true = c_f;
      4'b0011: cond_true = ~c_f;
      4'b0100: cond_true = n_f;
      4'b0101: cond_true = ~n_f;
      4'b0110: cond_true = v_f;
      4'b0111: cond_true = ~v_f;
      4'b1000: cond_true = c_f & ~z_f;
      4'b1001: cond_true = ~c_f | z_f;
      4'b1010: cond_true = (n_f == v_f);
      4'b1011: cond_true = (n_f != v_f);
      4'b1100: cond_true = ~z_f & (n_f == v_f);
      4'b1101: cond_true = z_f | (n_f != v_f);
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign it_start = vld & ITStart & ~in_it;
  assign it_nest  = vld & ITStart & in_it;
  assign it_step  = vld & ~ITStart & in_it;

  // 1111 is reserved only outside a block; inside one it simply never executes.
  assign Undef    = it_nest | (vld & ~ITStart & ~in_it & (Cond == 4'b1111));
  assign CondEx   = it_start | (vld & ~ITStart & cond_true & ~Undef);
  assign exec_op  = CondEx & ~it_start;

  assign PCSrc    = (PCS | Branch) & exec_op;
  assign RegWrite = RegW & exec_op;
  assign MemWrite = MemW & exec_op;
  assign ITActive = in_it;
  assign Flags    = {cur.nz, cur.cv};

  always_comb begin
    for (int i = 0; i < NCTX; i++) begin
      ctx_d[i] = ctx_q[i];
      if (Ctx == CW'(i)) begin
        if (exec_op && FlagW[1]) ctx_d[i].nz = ALUFlags[3:2];
        if (exec_op && FlagW[0]) ctx_d[i].cv = ALUFlags[1:0];
        if (it_start) begin
          ctx_d[i].cnt = {1'b0, ITLen} + 3'd1;
          ctx_d[i].cnd = ITCond;
          ctx_d[i].msk = ITMask;
        end else if (it_step) begin
          // A taken branch before the last slot abandons the rest of the block.
          ctx_d[i].cnt = (PCSrc && ctx_q[i].cnt > 3'd1) ? 3'd0 : ctx_q[i].cnt - 3'd1;
          ctx_d[i].msk = ctx_q[i].msk >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCTX; i++) begin
      // NOTE: the context file is plain flops, and every entry must come out
      // of reset with clear flags and no pending block, so all are cleared.
      if (reset) ctx_q[i] <= '0;
      // NOTE: state uses non-blocking assignment so every context updates
      // from the same pre-edge values regardless of statement order.
      else       ctx_q[i] <= ctx_d[i];
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed testbench for cond_unit with four contexts; expected values are
// hand-computed from the condition table and IT sequencing rules.
module tb_cond_unit;
  localparam int NCTX = 4;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          Valid;
  logic [CW-1:0] Ctx;
  logic [3:0]    Cond, ALUFlags, ITCond, ITMask;
  logic [1:0]    FlagW, ITLen;
  logic          PCS, RegW, MemW, Branch, ITStart;
  logic          PCSrc, RegWrite, MemWrite, CondEx, Undef, ITActive;
  logic [3:0]    Flags;

  int n_checks = 0;
  int n_errors = 0;

  cond_unit #(.NCTX(NCTX), .CW(CW)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .Ctx(Ctx), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen),
    .ITMask(ITMask), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondEx(CondEx), .Undef(Undef), .ITActive(ITActive), .Flags(Flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Observed bundle: {PCSrc,RegWrite,MemWrite,CondEx,Undef,ITActive,Flags}
  function automatic logic [9:0] outs();
    return {PCSrc, RegWrite, MemWrite, CondEx, Undef, ITActive, Flags};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear(input int c);
    Valid = 1'b0; Ctx = CW'(c); Cond = 4'b1110; ALUFlags = 4'b0000;
    FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; Branch = 1'b0;
    ITStart = 1'b0; ITCond = 4'b0000; ITLen = 2'b00; ITMask = 4'b0000;
  endtask

  task automatic instr(input int c, input logic [3:0] cond);
    clear(c);
    Valid = 1'b1;
    Cond  = cond;
  endtask

  task automatic it_instr(input int c, input logic [3:0] icond,
                          input logic [1:0] ilen, input logic [3:0] imask);
    clear(c);
    Valid = 1'b1; ITStart = 1'b1;
    ITCond = icond; ITLen = ilen; ITMask = imask;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear(0);
    tick();
    tick();
    for (int c = 0; c < NCTX; c++) begin
      Ctx = CW'(c);
      #1;
      n_checks++;
      if (outs() !== 10'b000000_0000) begin
        n_errors++;
        $display("FAIL reset_idle ctx%0d: got %b want %b", c, outs(), 10'b000000_0000);
      end
    end
    instr(0, 4'b0001); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b010100_0000) begin
      n_errors++; $display("FAIL reset_comb_ne: got %b want %b", outs(), 10'b010100_0000);
    end
    instr(0, 4'b0000); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b000000_0000) begin
      n_errors++; $display("FAIL reset_comb_eq: got %b want %b", outs(), 10'b000000_0000);
    end
    instr(0, 4'b1111); #1;
    n_checks++;
    if (outs() !== 10'b000010_0000) begin
      n_errors++; $display("FAIL reset_comb_rsvd: got %b want %b", outs(), 10'b000010_0000);
    end
    tick();
    clear(0);
    reset = 1'b0;
  endtask

  task automatic test_flags();
    instr(0, 4'b1110); FlagW = 2'b11; ALUFlags = 4'b0100; #1;
    n_checks++;
    if (outs() !== 10'b000100_0000) begin
      n_errors++; $display("FAIL flags_no_bypass: got %b want %b", outs(), 10'b000100_0000);
    end
    tick();
    clear(0); #1;
    n_checks++;
    if (outs() !== 10'b000000_0100) begin
      n_errors++; $display("FAIL flags_visible: got %b want %b", outs(), 10'b000000_0100);
    end
    instr(0, 4'b0000); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b010100_0100) begin
      n_errors++; $display("FAIL eq_regwrite: got %b want %b", outs(), 10'b010100_0100);
    end
    tick();
    instr(0, 4'b0001); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b000000_0100) begin
      n_errors++; $display("FAIL ne_regwrite: got %b want %b", outs(), 10'b000000_0100);
    end
    tick();
    instr(0, 4'b1101); MemW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b001100_0100) begin
      n_errors++; $display("FAIL le_memwrite: got %b want %b", outs(), 10'b001100_0100);
    end
    tick();
    instr(0, 4'b1000); PCS = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b000000_0100) begin
      n_errors++; $display("FAIL hi_pcsrc: got %b want %b", outs(), 10'b000000_0100);
    end
    tick();
    instr(0, 4'b1001); PCS = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b100100_0100) begin
      n_errors++; $display("FAIL ls_pcsrc: got %b want %b", outs(), 10'b100100_0100);
    end
    tick();
  endtask

  task automatic test_group_enables();
    instr(0, 4'b1110); FlagW = 2'b10; ALUFlags = 4'b1011;
    tick();
    clear(0); #1;
    n_checks++;
    if (outs() !== 10'b000000_1000) begin
      n_errors++; $display("FAIL group_nz_only: got %b want %b", outs(), 10'b000000_1000);
    end
    instr(0, 4'b0000); FlagW = 2'b11; ALUFlags = 4'b0111; #1;
    n_checks++;
    if (outs() !== 10'b000000_1000) begin
      n_errors++; $display("FAIL nonexec_cond: got %b want %b", outs(), 10'b000000_1000);
    end
    tick();
    clear(0); #1;
    n_checks++;
    if (outs() !== 10'b000000_1000) begin
      n_errors++; $display("FAIL nonexec_flags_kept: got %b want %b", outs(), 10'b000000_1000);
    end
    instr(0, 4'b0100); FlagW = 2'b01; ALUFlags = 4'b0011;
    tick();
    clear(0); #1;
    n_checks++;
    if (outs() !== 10'b000000_1011) begin
      n_errors++; $display("FAIL group_cv_only: got %b want %b", outs(), 10'b000000_1011);
    end
    instr(0, 4'b1011); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b000000_1011) begin
      n_errors++; $display("FAIL lt_false: got %b want %b", outs(), 10'b000000_1011);
    end
    tick();
    instr(0, 4'b1100); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b010100_1011) begin
      n_errors++; $display("FAIL gt_true: got %b want %b", outs(), 10'b010100_1011);
    end
    tick();
  endtask

  task automatic test_it_sequence();
    instr(0, 4'b1110); FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    it_instr(0, 4'b0000, 2'd2, 4'b0101);
    Cond = 4'b1111; RegW = 1'b1; MemW = 1'b1; Branch = 1'b1;
    FlagW = 2'b11; ALUFlags = 4'b1111; #1;
    n_checks++;
    if (outs() !== 10'b000100_0100) begin
      n_errors++; $display("FAIL it_start: got %b want %b", outs(), 10'b000100_0100);
    end
    tick();
    instr(0, 4'b0001); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b010101_0100) begin
      n_errors++; $display("FAIL it_instr1_then: got %b want %b", outs(), 10'b010101_0100);
    end
    tick();
    clear(0); #1;
    n_checks++;
    if (outs() !== 10'b000001_0100) begin
      n_errors++; $display("FAIL it_idle_holds: got %b want %b", outs(), 10'b000001_0100);
    end
    tick();
    instr(0, 4'b0000); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b000001_0100) begin
      n_errors++; $display("FAIL it_instr2_else: got %b want %b", outs(), 10'b000001_0100);
    end
    tick();
    instr(0, 4'b0001); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b010101_0100) begin
      n_errors++; $display("FAIL it_instr3_then: got %b want %b", outs(), 10'b010101_0100);
    end
    tick();
    clear(0); #1;
    n_checks++;
    if (outs() !== 10'b000000_0100) begin
      n_errors++; $display("FAIL it_block_done: got %b want %b", outs(), 10'b000000_0100);
    end
  endtask

  task automatic test_cancel_nesting();
    it_instr(0, 4'b1110, 2'd3, 4'b1111);
    tick();
    instr(0, 4'b0000); #1;
    n_checks++;
    if (outs() !== 10'b000101_0100) begin
      n_errors++; $display("FAIL cancel_instr1: got %b want %b", outs(), 10'b000101_0100);
    end
    tick();
    instr(0, 4'b0000); Branch = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b100101_0100) begin
      n_errors++; $display("FAIL cancel_branch: got %b want %b", outs(), 10'b100101_0100);
    end
    tick();
    clear(0); #1;
    n_checks++;
    if (outs() !== 10'b000000_0100) begin
      n_errors++; $display("FAIL cancel_inactive: got %b want %b", outs(), 10'b000000_0100);
    end
    it_instr(0, 4'b0000, 2'd1, 4'b0011);
    tick();
    it_instr(0, 4'b0000, 2'd3, 4'b0000);
    FlagW = 2'b11; ALUFlags = 4'b0000; RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b000011_0100) begin
      n_errors++; $display("FAIL nested_it_undef: got %b want %b", outs(), 10'b000011_0100);
    end
    tick();
    instr(0, 4'b0001); #1;
    n_checks++;
    if (outs() !== 10'b000101_0100) begin
      n_errors++; $display("FAIL nested_state_kept: got %b want %b", outs(), 10'b000101_0100);
    end
    tick();
    instr(0, 4'b0001); #1;
    n_checks++;
    if (outs() !== 10'b000101_0100) begin
      n_errors++; $display("FAIL nested_last: got %b want %b", outs(), 10'b000101_0100);
    end
    tick();
    clear(0); #1;
    n_checks++;
    if (outs() !== 10'b000000_0100) begin
      n_errors++; $display("FAIL nested_block_done: got %b want %b", outs(), 10'b000000_0100);
    end
    it_instr(0, 4'b1111, 2'd1, 4'b0010);
    tick();
    instr(0, 4'b0000); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b010101_0100) begin
      n_errors++; $display("FAIL it_1111_else_al: got %b want %b", outs(), 10'b010101_0100);
    end
    tick();
    instr(0, 4'b0000); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b000001_0100) begin
      n_errors++; $display("FAIL it_1111_never: got %b want %b", outs(), 10'b000001_0100);
    end
    tick();
  endtask

  task automatic test_isolation();
    logic [9:0] exp_ctx [NCTX];
    exp_ctx[0] = 10'b000000_0000;
    exp_ctx[1] = 10'b000000_1010;
    exp_ctx[2] = 10'b000001_0000;
    exp_ctx[3] = 10'b000000_0000;
    clear(0); reset = 1'b1;
    tick();
    reset = 1'b0;
    it_instr(2, 4'b1110, 2'd3, 4'b1111);
    tick();
    instr(1, 4'b1110); FlagW = 2'b11; ALUFlags = 4'b1111;
    tick();
    clear(1); #1;
    n_checks++;
    if (outs() !== 10'b000000_1111) begin
      n_errors++; $display("FAIL iso_ctx1_flags: got %b want %b", outs(), 10'b000000_1111);
    end
    instr(2, 4'b0000); #1;
    n_checks++;
    if (outs() !== 10'b000101_0000) begin
      n_errors++; $display("FAIL iso_ctx2_instr: got %b want %b", outs(), 10'b000101_0000);
    end
    tick();
    instr(1, 4'b1110); FlagW = 2'b11; ALUFlags = 4'b1010;
    tick();
    for (int c = 0; c < NCTX; c++) begin
      clear(c); #1;
      n_checks++;
      if (outs() !== exp_ctx[c]) begin
        n_errors++;
        $display("FAIL iso_ctx%0d_state: got %b want %b", c, outs(), exp_ctx[c]);
      end
    end
    instr(2, 4'b0000); tick();
    instr(0, 4'b1110); tick();
    instr(2, 4'b0000); tick();
    clear(2); #1;
    n_checks++;
    if (outs() !== 10'b000001_0000) begin
      n_errors++; $display("FAIL iso_ctx2_pending: got %b want %b", outs(), 10'b000001_0000);
    end
    instr(2, 4'b0000); tick();
    clear(2); #1;
    n_checks++;
    if (outs() !== 10'b000000_0000) begin
      n_errors++; $display("FAIL iso_ctx2_done: got %b want %b", outs(), 10'b000000_0000);
    end
    instr(0, 4'b1111); RegW = 1'b1; #1;
    n_checks++;
    if (outs() !== 10'b000010_0000) begin
      n_errors++; $display("FAIL iso_reserved_outside: got %b want %b", outs(), 10'b000010_0000);
    end
    tick();
  endtask

  task automatic test_reset_mid_block();
    it_instr(3, 4'b0000, 2'd3, 4'b1111);
    tick();
    instr(0, 4'b1110); FlagW = 2'b11; ALUFlags = 4'b1111;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < NCTX; c++) begin
      clear(c); #1;
      n_checks++;
      if (outs() !== 10'b000000_0000) begin
        n_errors++;
        $display("FAIL rst_mid_ctx%0d: got %b want %b", c, outs(), 10'b000000_0000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_group_enables();
    test_it_sequence();
    test_cancel_nesting();
    test_isolation();
    test_reset_mid_block();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
